mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Request-side controller sitting directly upstream of the single-port memory (sync write, async read, `Valid_out` low during writes). It accepts read/write requests over a valid/ready handshake and buffers them in a small FIFO. It serialises them onto the memory port and returns read data over a valid/ready response channel with back-pressure. The memory's ports (`W_en`, `Address`, `Data_in`, `Data_out`, `Valid_out`) connect 1:1 to `mem_*` below.

## Interface
- `ADDR_WIDTH`, 4, memory address width.
- `DATA_WIDTH`, 32, data width.
- `FIFO_DEPTH`, 4, request FIFO entries (power of two, ≥2).

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: target address.
- `req_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out DATA_WIDTH: read data.
- `rsp_addr` out ADDR_WIDTH: address of the read.
- `rsp_err` out 1: memory `Valid_out` was low at capture.
- `mem_w_en` out 1: to memory `W_en`.
- `mem_addr` out ADDR_WIDTH: to memory `Address`.
- `mem_wdata` out DATA_WIDTH: to memory `Data_in`.
- `mem_rdata` in DATA_WIDTH: from memory `Data_out`.
- `mem_valid` in 1: from memory `Valid_out`.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.

## Operation
- Push on `req_valid & req_ready`. `req_ready = (count != FIFO_DEPTH)` is taken from the registered count. A pop in the same cycle does not free a slot for that cycle's push.
- The command register `{we, addr, wdata}` holds the executing op. `mem_addr`/`mem_wdata` come from it. `mem_w_en = (state==EXEC & cmd.we)` (or CLEAR).
- FSM states:
  - **IDLE**: if FIFO non-empty, pop into cmd and go to EXEC.
  - **EXEC** (exactly 1 cycle): a write stores at the end of this cycle, then go to IDLE. A read captures `mem_rdata`, `mem_addr` and `~mem_valid` into the response registers, then go to RESP.
  - **RESP**: `rsp_valid=1` with data, addr and err stable until `rsp_valid & rsp_ready`, then go to IDLE. The FIFO keeps accepting pushes in this state.
- Ordering is strict FIFO; a read after a write to the same address returns the new data.
- Reset values: `req_ready=1` (FIFO empty), all other outputs 0, state IDLE, FIFO pointers and count 0.
- `rst` asserted mid-operation clears everything at once. Outstanding commands and any pending response are discarded, not replayed.

## Timing
- Write accepted at edge t: popped at t+1, `mem_w_en=1` during cycle t+1..t+2, memory updated at edge t+2.
- Read accepted at edge t: EXEC during t+1..t+2, `rsp_valid` high from edge t+2.
- Throughput: one write per 2 cycles. One read per 3 cycles with `rsp_ready` tied high.
- `mem_w_en` never asserts outside EXEC/CLEAR. It is never high during a read EXEC, so `mem_valid` must be 1 at capture.

## Configuration
- `MEM_CTRL_CLEAR_EN` defined adds:
  - Port `clr_start` (in 1) and port `clr_done` (out 1).
  - State **CLEAR**. `clr_start` sampled high in IDLE takes priority over a FIFO pop. CLEAR writes 0 to addresses 0..2^ADDR_WIDTH−1, one per cycle, with `mem_w_en=1`.
  - `clr_done` pulses for 1 cycle on the cycle after the last write, then the FSM returns to IDLE.
  - `clr_start` is ignored outside IDLE. The FIFO accepts pushes during CLEAR.
- `MEM_CTRL_CLEAR_EN` undefined: the ports, the state and the address counter are absent.

## Structure
- Package `mem_ctrl_pkg`: state enum (IDLE, EXEC, RESP, CLEAR), the `mem_cmd_t` struct `{we, addr, wdata}` and its width constants.
- Sub-module `mem_req_fifo`: synchronous FIFO of `mem_cmd_t` with full/empty/count outputs and the same async reset.

## Test plan
- Write 0xDEADBEEF to addr 3, then read addr 3 → `rsp_rdata=0xDEADBEEF`, `rsp_addr=3`, `rsp_err=0`, `rsp_valid` 2 cycles after read accept.
- Push 5 requests back-to-back with `FIFO_DEPTH=4` while a read response is stalled (`rsp_ready=0`) → `req_ready=0` after the 4th push; 5th accepted only after the stall releases; all executed in order.
- Hold `rsp_ready=0` for 10 cycles on a read of addr 7 (data 0x12345678) → `rsp_valid`, `rsp_rdata`, `rsp_addr` stable for all 10 cycles; no further memory op issued.
- Assert `rst` low during a read EXEC with 2 entries queued → all outputs 0, `req_ready=1`; after release the queued ops never appear on `mem_*`.
- Read of addr 0 after reset → `rsp_rdata=0`.
- `MEM_CTRL_CLEAR_EN`: fill all 16 addresses with 0xA5A5A5A5, pulse `clr_start` → 16 consecutive `mem_w_en` cycles with `mem_wdata=0`, then `clr_done` pulse; reads of addrs 0 and 15 return 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request controller: FSM states and the queued command word.
// Command field widths are fixed here and set the defaults of the top-level width parameters.
package mem_ctrl_pkg;

   localparam int CMD_ADDR_W = 4;
   localparam int CMD_DATA_W = 32;
   localparam int CMD_W      = 1 + CMD_ADDR_W + CMD_DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      RESP  = 2'd2,
      CLEAR = 2'd3
   } state_e;

   typedef struct packed {
      logic                  we;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO of mem_cmd_t; registered full/empty/count, read data from the head entry.
// Pushes while full and pops while empty are dropped; a same-cycle pop never frees a slot for the push.
module mem_req_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  mem_cmd_t                 push_dat_i,
   input  logic                     pop_i,
   output mem_cmd_t                 pop_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   mem_cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 do_push, do_pop;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign do_push   = push_i & ~full_o;
   assign do_pop    = pop_i & ~empty_o;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Queues read/write requests and serialises them onto a single-port memory; reads return via a stallable response.
// MEM_CTRL_CLEAR_EN adds clr_start/clr_done and a CLEAR state that zeroes the whole memory.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = CMD_ADDR_W,
   parameter int DATA_WIDTH = CMD_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic                  rsp_err,
   output logic                  mem_w_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_valid,
`ifdef MEM_CTRL_CLEAR_EN
   input  logic                  clr_start,
   output logic                  clr_done,
`endif
   output logic                  busy
);

   state_e                      state_q, state_d;
   mem_cmd_t                    cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0]       rsp_addr_q, rsp_addr_d;
   logic                        rsp_err_q, rsp_err_d;
   mem_cmd_t                    fifo_push_dat, fifo_pop_dat;
   logic                        fifo_pop, fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef MEM_CTRL_CLEAR_EN
   logic [ADDR_WIDTH-1:0]       clr_addr_q, clr_addr_d;
   logic                        clr_done_q, clr_done_d;
`endif

   assign fifo_push_dat = '{we: req_we, addr: req_addr, wdata: req_wdata};

   mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (req_valid),
      .push_dat_i (fifo_push_dat),
      .pop_i      (fifo_pop),
      .pop_dat_o  (fifo_pop_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign req_ready = ~fifo_full;
   assign busy      = (state_q != IDLE) | (fifo_count != '0);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_err   = rsp_err_q;
`ifdef MEM_CTRL_CLEAR_EN
   assign clr_done  = clr_done_q;
`endif

   always_comb begin
      mem_w_en  = (state_q == EXEC) & cmd_q.we;
      mem_addr  = cmd_q.addr;
      mem_wdata = cmd_q.wdata;
`ifdef MEM_CTRL_CLEAR_EN
      if (state_q == CLEAR) begin
         mem_w_en  = 1'b1;
         mem_addr  = clr_addr_q;
         mem_wdata = '0;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      fifo_pop    = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_err_d   = rsp_err_q;
`ifdef MEM_CTRL_CLEAR_EN
      clr_addr_d  = clr_addr_q;
      clr_done_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef MEM_CTRL_CLEAR_EN
            if (clr_start) begin
               clr_addr_d = '0;
               state_d    = CLEAR;
            end else
`endif
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_pop_dat;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            // The write itself lands at the end of this cycle via mem_w_en.
            if (cmd_q.we) begin
               state_d = IDLE;
            end else begin
               rsp_rdata_d = mem_rdata;
               rsp_addr_d  = mem_addr;
               rsp_err_d   = ~mem_valid;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
`ifdef MEM_CTRL_CLEAR_EN
         CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (&clr_addr_q) begin
               clr_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_addr_q  <= '0;
         rsp_err_q   <= 1'b0;
`ifdef MEM_CTRL_CLEAR_EN
         clr_addr_q  <= '0;
         clr_done_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_err_q   <= rsp_err_d;
`ifdef MEM_CTRL_CLEAR_EN
         clr_addr_q  <= clr_addr_d;
         clr_done_q  <= clr_done_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural single-port memory attached to mem_*.
// Build with MEM_CTRL_CLEAR_EN defined to include the memory-clear sequence.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [3:0]  rsp_addr;
   logic        mem_w_en, mem_valid;
   logic [3:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        busy;
`ifdef MEM_CTRL_CLEAR_EN
   logic        clr_start, clr_done;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mem_arr [16];
   logic [35:0] wlog [$];
   logic [35:0] rlog [$];
   logic        rsp_valid_prev = 1'b0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .mem_w_en  (mem_w_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
`ifdef MEM_CTRL_CLEAR_EN
      .clr_start (clr_start),
      .clr_done  (clr_done),
`endif
      .busy      (busy)
   );

   // Memory: synchronous write, asynchronous read, Valid_out low while writing.
   always @(posedge clk) begin
      if (mem_w_en) mem_arr[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem_arr[mem_addr];
   assign mem_valid = ~mem_w_en;

   always @(negedge clk) begin
      if (mem_w_en) wlog.push_back({mem_addr, mem_wdata});
      if (rsp_valid && !rsp_valid_prev) rlog.push_back({rsp_addr, rsp_rdata});
      rsp_valid_prev = rsp_valid;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      chk("wr_t1_wen", mem_w_en, 0);
      @(negedge clk);
      chk("wr_exec_wen", mem_w_en, 1);
      chk("wr_exec_addr", mem_addr, a);
      chk("wr_exec_wdata", mem_wdata, d);
      @(negedge clk);
      chk("wr_done_wen", mem_w_en, 0);
   endtask

   task automatic rd_check(input logic [3:0] a, input logic [31:0] expd);
      chk("rd_req_ready", req_ready, 1);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_no_rsp_t1", rsp_valid, 0);
      @(negedge clk);
      chk("rd_exec_addr", mem_addr, a);
      chk("rd_exec_wen", mem_w_en, 0);
      chk("rd_no_rsp_t2", rsp_valid, 0);
      @(negedge clk);
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rdata", rsp_rdata, expd);
      chk("rd_raddr", rsp_addr, a);
      chk("rd_err", rsp_err, 0);
      @(negedge clk);
      chk("rd_rsp_drop", rsp_valid, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) mem_arr[i] = '0;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
`ifdef MEM_CTRL_CLEAR_EN
      clr_start = 1'b0;
`endif
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_w_en", mem_w_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_busy", busy, 0);
`ifdef MEM_CTRL_CLEAR_EN
      chk("rst_clr_done", clr_done, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      rd_check(4'd0, 32'h0);
      wr(4'd3, 32'hDEAD_BEEF);
      rd_check(4'd3, 32'hDEAD_BEEF);

      // Response held off for 10 cycles.
      wr(4'd7, 32'h1234_5678);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, 32'h1234_5678);
         chk("hold_addr", rsp_addr, 7);
         chk("hold_no_wen", mem_w_en, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release", rsp_valid, 0);
      wait_idle();

      // Fill the FIFO behind a stalled response.
      wlog.delete(); rlog.delete();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      for (int i = 0; i < 4; i++) begin
         chk("fill_ready", req_ready, 1);
         req_valid = 1'b1; req_we = 1'b1; req_addr = 4'(8 + i); req_wdata = 32'hC0DE_0000 + 32'(8 + i);
         @(negedge clk);
      end
      chk("full_ready", req_ready, 0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9; req_wdata = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("full_hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      n = 0;
      @(negedge clk);
      n++;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("fifth_wait", n, 2);
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
      chk("ord_wcount", wlog.size(), 4);
      for (int i = 0; i < wlog.size() && i < 4; i++) begin
         chk("ord_waddr", wlog[i][35:32], 8 + i);
         chk("ord_wdata", wlog[i][31:0], 32'hC0DE_0000 + 32'(8 + i));
      end
      chk("ord_rcount", rlog.size(), 2);
      if (rlog.size() == 2) begin
         chk("ord_r0", rlog[0], {4'd3, 32'hDEAD_BEEF});
         chk("ord_r1", rlog[1], {4'd9, 32'hC0DE_0009});
      end

      // Reset during a read EXEC with two writes queued.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
      @(negedge clk);
      req_we = 1'b1; req_addr = 4'd12; req_wdata = 32'hBAD0_000C;
      @(negedge clk);
      req_addr = 4'd13; req_wdata = 32'hBAD0_000D;
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_exec_addr", mem_addr, 7);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_rdata", rsp_rdata, 0);
      chk("mid_rst_rsp_addr", rsp_addr, 0);
      chk("mid_rst_mem_w_en", mem_w_en, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      chk("mid_rst_mem_wdata", mem_wdata, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      wlog.delete(); rlog.delete();
      repeat (10) @(negedge clk);
      chk("post_rst_no_writes", wlog.size(), 0);
      chk("post_rst_no_rsp", rlog.size(), 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_mem12", mem_arr[12], 0);
      chk("post_rst_mem13", mem_arr[13], 0);

`ifdef MEM_CTRL_CLEAR_EN
      for (int a = 0; a < 16; a++) wr(4'(a), 32'hA5A5_A5A5);
      chk("fill_mem15", mem_arr[15], 32'hA5A5_A5A5);
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("clr_wen", mem_w_en, 1);
         chk("clr_addr", mem_addr, i);
         chk("clr_wdata", mem_wdata, 0);
         chk("clr_done_early", clr_done, 0);
         @(negedge clk);
      end
      chk("clr_done_pulse", clr_done, 1);
      chk("clr_wen_off", mem_w_en, 0);
      @(negedge clk);
      chk("clr_done_drop", clr_done, 0);
      rd_check(4'd0, 32'h0);
      rd_check(4'd15, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
